matvec_sequencer: RTL and testbench

Top-level sequencer for the 8x8 matrix-vector multiply datapath. It clears the MAC array, then starts the memory fetch engine that loads the eight A-row FIFOs and the shared B FIFO. Once the fetch completes, it drains all nine FIFOs in lockstep into eight MAC lanes and captures the eight dot-product results. It also reports busy/done/error status and a cycle count for the whole operation.

---
 rtl/matvec_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_matvec_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_sequencer.sv
// Top-level sequencer for the 8x8 matrix-vector multiply datapath: clears the MAC array,
// kicks the fetch engine, drains the A/B FIFOs in lockstep into the MAC lanes and captures results.
module matvec_sequencer #(
  parameter int N       = 8,
  parameter int K       = 8,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 1,
  parameter int RES_W   = 24,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      go,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      fetch_start,
  input  logic                      fetch_done,
  input  logic [N-1:0]              fifo_a_empty,
  output logic [N-1:0]              fifo_a_rd_en,
  input  logic                      fifo_b_empty,
  output logic                      fifo_b_rd_en,
  output logic                      mac_clr,
  output logic                      mac_en,
  input  logic [N-1:0][RES_W-1:0]   mac_result,
  output logic [N-1:0][RES_W-1:0]   result,
  output logic                      result_valid,
  output logic [15:0]               cycle_count
);

  localparam int ISS_W  = 4;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int DRN    = RD_LAT + MAC_LAT;
  localparam int DRN_W  = $clog2(DRN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_RUN,
    S_DRAIN,
    S_CAPTURE
  } state_t;

  state_t              state_reg, state_next;
  logic [WAIT_W-1:0]   wait_reg, wait_next;
  logic [ISS_W-1:0]    iss_reg, iss_next;
  logic [DRN_W-1:0]    drn_reg, drn_next;
  logic [RD_LAT-1:0]   mac_pipe_reg;
  logic                error_reg;
  logic                result_valid_reg;
  logic [15:0]         cyc_reg;
  logic [RES_W-1:0]    result_reg [N];
  logic                issue;
  logic                accept;
  logic                timeout_hit;

  // A read only happens when every FIFO has data, so the lanes never drift apart.
  assign issue  = (state_reg == S_RUN) && !(|fifo_a_empty) && !fifo_b_empty
                  && (iss_reg < ISS_W'(K));
  assign accept = (state_reg == S_IDLE) && go;

  always_comb begin
    state_next  = state_reg;
    wait_next   = wait_reg;
    iss_next    = iss_reg;
    drn_next    = drn_reg;
    timeout_hit = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (go) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        state_next = S_FETCH;
        wait_next  = '0;
      end
      S_FETCH: begin
        if (fetch_done) begin
          state_next = S_RUN;
          iss_next   = '0;
        end else if (wait_reg == WAIT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end
      S_RUN: begin
        if (issue) begin
          iss_next = iss_reg + ISS_W'(1);
          if (iss_reg == ISS_W'(K - 1)) begin
            state_next = S_DRAIN;
            drn_next   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drn_reg == DRN_W'(DRN - 1)) state_next = S_CAPTURE;
        else                            drn_next   = drn_reg + DRN_W'(1);
      end
      S_CAPTURE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      wait_reg  <= '0;
      iss_reg   <= '0;
      drn_reg   <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      iss_reg   <= iss_next;
      drn_reg   <= drn_next;
    end
  end

  // mac_en follows the issue strobe by the FIFO read latency, in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_pipe_reg <= '0;
    end else begin
      mac_pipe_reg[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) mac_pipe_reg[i] <= mac_pipe_reg[i-1];
    end
  end

  // The count loads 1 on acceptance so the done cycle itself is included in the total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_reg <= '0;
    end else if (accept) begin
      cyc_reg <= 16'd1;
    end else if ((state_reg != S_IDLE) && (state_next != S_IDLE) && (cyc_reg != 16'hFFFF)) begin
      cyc_reg <= cyc_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_reg        <= 1'b0;
      result_valid_reg <= 1'b0;
    end else if (accept) begin
      error_reg        <= 1'b0;
      result_valid_reg <= 1'b0;
    end else begin
      if (timeout_hit)              error_reg        <= 1'b1;
      if (state_reg == S_CAPTURE)   result_valid_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) result_reg[i] <= '0;
    end else if (state_reg == S_CAPTURE) begin
      for (int i = 0; i < N; i++) result_reg[i] <= mac_result[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign result[gi]       = result_reg[gi];
      assign fifo_a_rd_en[gi] = issue;
    end
  endgenerate

  assign fifo_b_rd_en = issue;
  assign mac_en       = mac_pipe_reg[RD_LAT-1];
  assign busy         = (state_reg != S_IDLE);
  assign done         = (state_reg == S_CAPTURE);
  assign mac_clr      = (state_reg == S_CLEAR);
  assign fetch_start  = (state_reg == S_FETCH) && (wait_reg == '0);
  assign error        = error_reg;
  assign result_valid = result_valid_reg;
  assign cycle_count  = cyc_reg;

endmodule

// File: tb/tb_matvec_sequencer.sv
// Bench for matvec_sequencer: models the fetch engine, nine FIFOs and MAC lanes, and checks
// results against plain dot-product arithmetic and latencies against closed-form timing.
module tb_matvec_sequencer;

  localparam int N       = 8;
  localparam int K       = 8;
  localparam int RD_LAT  = 1;
  localparam int MAC_LAT = 1;
  localparam int RES_W   = 24;
  localparam int TIMEOUT = 1024;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    go = 1'b0;
  logic                    fetch_done = 1'b0;
  logic                    busy, done, error, fetch_start;
  logic [N-1:0]            fifo_a_empty, fifo_a_rd_en;
  logic                    fifo_b_empty, fifo_b_rd_en;
  logic                    mac_clr, mac_en, result_valid;
  logic [N-1:0][RES_W-1:0] mac_result, result;
  logic [15:0]             cycle_count;

  matvec_sequencer #(.N(N), .K(K), .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT),
                     .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .done(done), .error(error),
    .fetch_start(fetch_start), .fetch_done(fetch_done),
    .fifo_a_empty(fifo_a_empty), .fifo_a_rd_en(fifo_a_rd_en),
    .fifo_b_empty(fifo_b_empty), .fifo_b_rd_en(fifo_b_rd_en),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_result(mac_result),
    .result(result), .result_valid(result_valid), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Environment: FIFO contents, read pointers, B-stall injection and MAC lanes.
  logic [7:0]       a_mem [N][K];
  logic [7:0]       b_mem [K];
  int               a_ptr [N] = '{default: 0};
  int               b_ptr = 0;
  bit               loaded = 1'b0;
  int               stall_left = 0;
  int               stall_at_cfg = 0;
  int               stall_len_cfg = 0;
  bit               bad_pop = 1'b0;
  logic [7:0]       a_q [N];
  logic [7:0]       b_q = '0;
  logic [RES_W-1:0] acc [N] = '{default: '0};

  always_comb begin
    for (int i = 0; i < N; i++) fifo_a_empty[i] = !loaded || (a_ptr[i] >= K);
    fifo_b_empty = !loaded || (b_ptr >= K) || (stall_left != 0);
    for (int i = 0; i < N; i++) mac_result[i] = acc[i];
  end

  always @(posedge clk) begin
    if (fetch_start) begin
      loaded     <= 1'b0;
      b_ptr      <= 0;
      stall_left <= 0;
      for (int i = 0; i < N; i++) a_ptr[i] <= 0;
    end else begin
      if (fetch_done) loaded <= 1'b1;
      if (stall_left > 0) stall_left <= stall_left - 1;
      if (fifo_b_rd_en) begin
        if (fifo_b_empty) bad_pop <= 1'b1;
        else              b_q <= b_mem[b_ptr];
        b_ptr <= b_ptr + 1;
        if (b_ptr + 1 == stall_at_cfg) stall_left <= stall_len_cfg;
      end
      for (int i = 0; i < N; i++) begin
        if (fifo_a_rd_en[i]) begin
          if (fifo_a_empty[i]) bad_pop <= 1'b1;
          else                 a_q[i] <= a_mem[i][a_ptr[i]];
          a_ptr[i] <= a_ptr[i] + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (mac_clr)     acc[i] <= '0;
      else if (mac_en) acc[i] <= acc[i] + RES_W'(a_q[i]) * RES_W'(b_q);
    end
  end

  task automatic fill(input int mode);
    for (int k = 0; k < K; k++) begin
      b_mem[k] = (mode == 1) ? 8'(k + 1) : (mode == 2) ? 8'hFF : 8'($urandom_range(0, 255));
      for (int i = 0; i < N; i++)
        a_mem[i][k] = (mode == 1) ? ((i == k) ? 8'd1 : 8'd0)
                    : (mode == 2) ? 8'hFF : 8'($urandom_range(0, 255));
    end
  endtask

  function automatic int ref_dot(input int i);
    int s = 0;
    for (int k = 0; k < K; k++) s += int'(a_mem[i][k]) * int'(b_mem[k]);
    return s;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {busy, done, error, fetch_start, fifo_b_rd_en, mac_clr, mac_en, result_valid}, 0);
    check({tag, "_rd_a"}, fifo_a_rd_en, 0);
    check({tag, "_cyc"}, cycle_count, 0);
    for (int i = 0; i < N; i++) check({tag, "_result"}, result[i], 0);
  endtask

  // Pulse go, verify CLEAR/FETCH timing, deliver fetch_done F cycles after fetch_start.
  // Returns at the negedge of the first RUN cycle (n = 3 + F).
  task automatic start_op(input int f_lat, output int n);
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    n = 1;
    check("clear_cycle", {busy, mac_clr, fetch_start}, 3'b110);
    check("go_clears", {error, result_valid}, 2'b00);
    @(negedge clk) n++;
    check("fetch_start", {busy, mac_clr, fetch_start}, 3'b101);
    for (int i = 0; i < f_lat; i++) begin
      @(negedge clk) n++;
      check("fetch_wait", {busy, fetch_start}, 2'b10);
    end
    fetch_done = 1'b1;
    @(negedge clk) n++;
    fetch_done = 1'b0;
  endtask

  task automatic run_op(input int mode, input int f_lat, input int stall_at,
                        input int stall_len, input bit go_in_run);
    int n, issues, macs, exp_lat;
    bit got_done;
    fill(mode);
    stall_at_cfg  = stall_at;
    stall_len_cfg = stall_len;
    exp_lat = 2 + f_lat + K + RD_LAT + MAC_LAT + 1 + ((stall_at > 0 && stall_at < K) ? stall_len : 0);
    start_op(f_lat, n);
    issues = 0;
    macs = 0;
    got_done = 1'b0;
    while (!got_done && n < 400) begin
      if (fifo_b_rd_en || (|fifo_a_rd_en))
        check("rd_en_lockstep", fifo_a_rd_en, {N{fifo_b_rd_en}});
      if (fifo_b_rd_en) issues++;
      if (mac_en) macs++;
      if (done) begin
        got_done = 1'b1;
      end else begin
        go = go_in_run && (n == 5 + f_lat);
        @(negedge clk) n++;
      end
    end
    go = 1'b0;
    check("done_seen", got_done, 1);
    check("done_latency", n, exp_lat);
    check("cycle_count", cycle_count, exp_lat);
    check("issue_count", issues, K);
    check("mac_en_count", macs, K);
    check("no_bad_pop", bad_pop, 0);
    @(negedge clk);
    check("done_one_cycle", {done, busy, result_valid}, 3'b001);
    check("cycle_count_hold", cycle_count, exp_lat);
    for (int i = 0; i < N; i++) check($sformatf("result[%0d]", i), result[i], ref_dot(i));
    $display("run mode=%0d F=%0d stall_at=%0d stall_len=%0d go_in_run=%0d latency=%0d",
             mode, f_lat, stall_at, stall_len, go_in_run, n);
  endtask

  task automatic timeout_op();
    int n, dones;
    dones = 0;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    n = 1;
    while (busy && n < TIMEOUT + 50) begin
      if (done) dones++;
      @(negedge clk) n++;
    end
    check("timeout_at", n, TIMEOUT + 2);
    check("timeout_state", {busy, error, result_valid}, 3'b010);
    check("timeout_no_done", dones, 0);
    $display("timeout run: busy dropped after %0d cycles, error=%0b", n, error);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // fetch_done while idle must not start anything
    @(negedge clk) fetch_done = 1'b1;
    @(negedge clk) fetch_done = 1'b0;
    check("idle_fetch_done", {busy, fetch_start, mac_clr}, 0);
    @(negedge clk);
    check("idle_fetch_done2", {busy, done}, 0);
    $display("fetch_done pulsed in IDLE: busy=%0b", busy);

    run_op(1, 20, 0, 0, 1'b0);
    run_op(2, $urandom_range(0, 30), 0, 0, 1'b0);
    run_op(0, $urandom_range(0, 30), 4, 3, 1'b0);
    run_op(0, $urandom_range(0, 30), 0, 0, 1'b1);
    for (int r = 0; r < 4; r++)
      run_op(0, $urandom_range(0, 40), $urandom_range(1, K - 1), $urandom_range(1, 4), 1'b0);

    timeout_op();
    run_op(0, $urandom_range(0, 30), 0, 0, 1'b0);

    // reset in the middle of RUN, then a clean run
    fill(0);
    start_op(5, n);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_run");
    $display("reset asserted mid-RUN: busy=%0b mac_en=%0b", busy, mac_en);
    @(negedge clk) rst_n = 1'b1;
    run_op(0, $urandom_range(0, 30), $urandom_range(1, K - 1), 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
